// File: rtl/sqrt_mag_ctrl_pkg.sv
// Shared definitions for the magnitude estimator: FSM states, operator
// codes for the shared abs/min/max unit and the default datapath width.
package sqrt_mag_ctrl_pkg;

   localparam int DATA_WIDTH = 16;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ABS_A = 3'd1,
      S_ABS_B = 3'd2,
      S_MAX   = 3'd3,
      S_MIN   = 3'd4,
      S_COMB  = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_ABS  = 2'b01,
      OP_MIN  = 2'b10,
      OP_MAX  = 2'b11
   } op_t;

   // Operator the shared unit must perform while the FSM sits in state s.
   function automatic op_t op_for(input state_t s);
      op_t op;
      case (s)
         S_ABS_A, S_ABS_B: op = OP_ABS;
         S_MAX:            op = OP_MAX;
         S_MIN:            op = OP_MIN;
         default:          op = OP_NONE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/sqrt_mag_ctrl_if.sv
// Request/response bundle of the magnitude estimator. The op field exposes
// the operator currently applied by the shared unit for observation.
interface sqrt_mag_ctrl_if
   import sqrt_mag_ctrl_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] mag;
   op_t              op;

   modport master (output start, a, b, input ready, busy, done, mag, op);
   modport slave  (input start, a, b, output ready, busy, done, mag, op);
endinterface

// File: rtl/sqrt_mag_ctrl_absminmax.sv
// Shared combinational operator: saturating absolute value of op_a,
// or unsigned min/max of op_a and op_b, selected by op.
module AbsMinMax_16bit
   import sqrt_mag_ctrl_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH
)
(
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  op_t              op,
   output logic [WIDTH-1:0] res
);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] sat_s;

   // Clamp the most negative value first so that negation cannot wrap.
   always_comb begin
      sat_s = (op_a == MOST_NEG) ? MOST_POS : op_a;
      res   = {WIDTH{1'b0}};
      case (op)
         OP_ABS:  res = sat_s[WIDTH-1] ? (~sat_s + ONE) : sat_s;
         OP_MIN:  res = (op_a < op_b) ? op_a : op_b;
         OP_MAX:  res = (op_a < op_b) ? op_b : op_a;
         default: res = {WIDTH{1'b0}};
      endcase
   end
endmodule

// File: rtl/sqrt_mag_ctrl.sv
// Magnitude estimator: mag ~ sqrt(a^2+b^2) computed as
// max(x, x - x/8 + y/2) with x/y the larger/smaller of |a|, |b|.
// One shared abs/min/max unit is sequenced through ABS_A..MIN.
module sqrt_mag_ctrl
   import sqrt_mag_ctrl_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH
)
(
   input logic           clk,
   input logic           rst_n,
   sqrt_mag_ctrl_if.slave bus
);
   state_t           state_r, next_s;
   op_t              op_r;
   logic             ready_r, busy_r, done_r, accept_s;
   logic [WIDTH-1:0] a_l_r, b_l_r, abs_a_r, abs_b_r, x_r, y_r, mag_r;
   logic [WIDTH-1:0] unit_a_s, unit_b_s, unit_res_s;
   logic [WIDTH:0]   t_r, t_s, x_ext_s;
   logic             unused_t_s;

   assign accept_s   = bus.start && ready_r;
   assign bus.ready  = ready_r;
   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.mag    = mag_r;
   assign bus.op     = op_r;
   assign unused_t_s = ^t_r;

   AbsMinMax_16bit #(.WIDTH(WIDTH)) u_amm (
      .op_a (unit_a_s),
      .op_b (unit_b_s),
      .op   (op_r),
      .res  (unit_res_s)
   );

   // Next-state logic of the sequencer.
   always_comb begin
      next_s = state_r;
      case (state_r)
         S_IDLE:  next_s = accept_s ? S_ABS_A : S_IDLE;
         S_ABS_A: next_s = S_ABS_B;
         S_ABS_B: next_s = S_MAX;
         S_MAX:   next_s = S_MIN;
         S_MIN:   next_s = S_COMB;
         S_COMB:  next_s = S_DONE;
         S_DONE:  next_s = accept_s ? S_ABS_A : S_IDLE;
         default: next_s = S_IDLE;
      endcase
   end

   // Operand routing into the shared unit and the combine-step arithmetic.
   always_comb begin
      unit_a_s = {WIDTH{1'b0}};
      unit_b_s = {WIDTH{1'b0}};
      case (state_r)
         S_ABS_A: unit_a_s = a_l_r;
         S_ABS_B: unit_a_s = b_l_r;
         S_MAX, S_MIN: begin
            unit_a_s = abs_a_r;
            unit_b_s = abs_b_r;
         end
         default: unit_a_s = {WIDTH{1'b0}};
      endcase
      x_ext_s = {1'b0, x_r};
      t_s     = x_ext_s - (x_ext_s >> 3'd3) + ({1'b0, y_r} >> 1'd1);
   end

   // State register plus status/op outputs registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         op_r    <= OP_NONE;
      end else begin
         state_r <= next_s;
         ready_r <= (next_s == S_IDLE) || (next_s == S_DONE);
         busy_r  <= (next_s != S_IDLE) && (next_s != S_DONE);
         done_r  <= (next_s == S_DONE);
         op_r    <= op_for(next_s);
      end
   end

   // Operand latch and per-step capture of intermediate results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_l_r   <= {WIDTH{1'b0}};
         b_l_r   <= {WIDTH{1'b0}};
         abs_a_r <= {WIDTH{1'b0}};
         abs_b_r <= {WIDTH{1'b0}};
         x_r     <= {WIDTH{1'b0}};
         y_r     <= {WIDTH{1'b0}};
         t_r     <= {(WIDTH+1){1'b0}};
         mag_r   <= {WIDTH{1'b0}};
      end else begin
         if (accept_s) begin
            a_l_r <= bus.a;
            b_l_r <= bus.b;
         end
         case (state_r)
            S_ABS_A: abs_a_r <= unit_res_s;
            S_ABS_B: abs_b_r <= unit_res_s;
            S_MAX:   x_r     <= unit_res_s;
            S_MIN:   y_r     <= unit_res_s;
            S_COMB: begin
               t_r   <= t_s;
               mag_r <= (t_s > x_ext_s) ? t_s[WIDTH-1:0] : x_r;
            end
            default: begin
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sqrt_mag_ctrl.sv
// Self-checking bench for sqrt_mag_ctrl: a cycle-phase reference model with
// an arithmetic magnitude function, a per-cycle compare process, and
// directed requests with hand-computed expectations.
module tb_sqrt_mag_ctrl;
   import sqrt_mag_ctrl_pkg::*;

   localparam int W = 16;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   sqrt_mag_ctrl_if #(.WIDTH(W)) bus ();
   sqrt_mag_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   // Saturating absolute value of a 16-bit two's-complement operand.
   function automatic int sat_abs(input logic [15:0] v);
      int s;
      s = int'($signed(v));
      if (s == -32768) return 32767;
      return (s < 0) ? -s : s;
   endfunction

   // Reference magnitude: max(x, x - x/8 + y/2) with integer truncation.
   function automatic int ref_mag(input logic [15:0] av, input logic [15:0] bv);
      int ax, bx, x, y, t;
      ax = sat_abs(av);
      bx = sat_abs(bv);
      x  = (ax > bx) ? ax : bx;
      y  = (ax > bx) ? bx : ax;
      t  = x - x / 8 + y / 2;
      return (t > x) ? t : x;
   endfunction

   // Operator expected k cycles after acceptance (k=1..5), 0 otherwise.
   function automatic int exp_op(input int k);
      case (k)
         1, 2:    return 1;
         3:       return 3;
         4:       return 2;
         default: return 0;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: m_phase counts cycles since the accepting edge
   // (0 = idle, 1..5 computing, 6 = result cycle).
   int m_phase, m_pending, m_mag;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase   <= 0;
         m_pending <= 0;
         m_mag     <= 0;
      end else if ((m_phase == 0 || m_phase == 6) && bus.start) begin
         m_phase   <= 1;
         m_pending <= ref_mag(bus.a, bus.b);
      end else if (m_phase >= 1 && m_phase <= 4) begin
         m_phase <= m_phase + 1;
      end else if (m_phase == 5) begin
         m_phase <= 6;
         m_mag   <= m_pending;
      end else begin
         m_phase <= 0;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      check("ready", int'(bus.ready), int'(m_phase == 0 || m_phase == 6));
      check("busy",  int'(bus.busy),  int'(m_phase >= 1 && m_phase <= 5));
      check("done",  int'(bus.done),  int'(m_phase == 6));
      check("mag",   int'(bus.mag),   m_mag);
      check("op",    int'(bus.op),    exp_op(m_phase));
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // One request from a ready state; checks latency, busy length and result.
   task automatic run_req(input logic [15:0] av, input logic [15:0] bv,
                          input int exp_mag, input string tag);
      int k, busy_cnt;
      bit seen;
      bus.start = 1'b1;
      bus.a     = av;
      bus.b     = bv;
      tick(1);
      bus.start = 1'b0;
      bus.a     = 16'($urandom);
      bus.b     = 16'($urandom);
      k = 1;
      busy_cnt = 0;
      seen = 1'b0;
      while (!seen && k <= 20) begin
         if (bus.busy) busy_cnt++;
         if (bus.done) seen = 1'b1;
         else begin
            tick(1);
            k++;
         end
      end
      check({tag, "_latency"}, k, 6);
      check({tag, "_busy_cycles"}, busy_cnt, 5);
      check({tag, "_mag"}, int'(bus.mag), exp_mag);
      tick(1);
      check({tag, "_done_pulse"}, int'(bus.done), 0);
      check({tag, "_mag_hold"}, int'(bus.mag), exp_mag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      bus.start = 1'b0;
      bus.a     = 16'd0;
      bus.b     = 16'd0;
      rst_n     = 1'b1;
      #1 rst_n  = 1'b0;
      tick(2);
      check("rst_ready", int'(bus.ready), 1);
      check("rst_busy",  int'(bus.busy),  0);
      check("rst_done",  int'(bus.done),  0);
      check("rst_mag",   int'(bus.mag),   0);
      check("rst_op",    int'(bus.op),    0);

      check("model_3_4",     ref_mag(16'd3, 16'd4), 5);
      check("model_m100_0",  ref_mag(16'hFF9C, 16'd0), 100);
      check("model_sat",     ref_mag(16'h8000, 16'h8000), 45055);
      check("model_6_8",     ref_mag(16'd6, 16'd8), 10);

      @(negedge clk) rst_n = 1'b1;
      run_req(16'd3,     16'd4,     5,     "r3_4");
      run_req(16'hFF9C,  16'd0,     100,   "rm100_0");
      run_req(16'h8000,  16'h8000,  45055, "rsat");
      run_req(16'd7,     16'hFFF9,  10,    "r7_m7");
      run_req(16'h7FFF,  16'd0,     32767, "rmax_0");
      run_req(16'd1,     16'd1,     1,     "r1_1");

      // Back-to-back with an ignored start while busy.
      bus.start = 1'b1; bus.a = 16'd3; bus.b = 16'd4;
      tick(1);
      bus.start = 1'b0;
      tick(1);
      bus.start = 1'b1; bus.a = 16'd7; bus.b = 16'd7;
      tick(1);
      bus.start = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom);
      tick(3);
      check("b2b_first_done", int'(bus.done), 1);
      check("b2b_first_mag",  int'(bus.mag),  5);
      bus.start = 1'b1; bus.a = 16'd0; bus.b = 16'd0;
      tick(1);
      bus.start = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom);
      check("b2b_done_low", int'(bus.done), 0);
      check("b2b_busy",     int'(bus.busy), 1);
      tick(5);
      check("b2b_second_done", int'(bus.done), 1);
      check("b2b_second_mag",  int'(bus.mag),  0);
      tick(1);

      // Reset in the middle of a computation.
      run_req(16'd12, 16'd5, 13, "r12_5");
      bus.start = 1'b1; bus.a = 16'd3; bus.b = 16'd4;
      tick(1);
      bus.start = 1'b0;
      tick(2);
      check("pre_abort_op_max", int'(bus.op), 3);
      #1 rst_n = 1'b0;
      #1;
      check("abort_ready", int'(bus.ready), 1);
      check("abort_busy",  int'(bus.busy),  0);
      check("abort_done",  int'(bus.done),  0);
      check("abort_mag",   int'(bus.mag),   0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      run_req(16'd6, 16'd8, 10, "r6_8");
      tick(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sqrt_mag_ctrl.md
SQRT_MAG_CTRL -- requirements
Module: sqrt_mag_ctrl

Interface
REQ-001 Parameter: WIDTH, default 16, operand and result width.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; operands sampled on the edge where start=1 and ready=1.
REQ-005 a  input  WIDTH  signed two's-complement operand (real part).
REQ-006 b  input  WIDTH  signed two's-complement operand (imaginary part).
REQ-007 ready  output  1  high when a new start will be accepted (IDLE or DONE).
REQ-008 busy  output  1  high while a computation is in progress (ABS_A..COMB).
REQ-009 done  output  1  one-cycle pulse when mag is valid.
REQ-010 mag  output  WIDTH  unsigned magnitude estimate ~ sqrt(a^2+b^2); held until the next done.

Function
REQ-011 Result SHALL equal max(x, x - (x>>3) + (y>>1)), where x=max(|a|,|b|) and y=min(|a|,|b|), using integer shifts with truncation.
REQ-012 FSM states SHALL be IDLE, ABS_A, ABS_B, MAX, MIN, COMB, DONE.
REQ-013 Transitions: IDLE->ABS_A on start; ABS_A->ABS_B->MAX->MIN->COMB->DONE unconditionally; DONE->ABS_A if start, otherwise DONE->IDLE.
REQ-014 Each non-IDLE state SHALL last exactly one cycle; done SHALL be high in DONE only, 6 cycles after the accepting edge.
REQ-015 A start while busy=1 SHALL be ignored, with no effect on state, operands or mag.
REQ-016 Operands SHALL be latched on acceptance; changes on a/b during busy SHALL NOT affect the result.
REQ-017 A single shared abs/min/max unit SHALL perform all abs, max and min steps, with Op driven by the FSM: ABS_A/ABS_B=01 (abs), MIN=10, MAX=11; the Op value in IDLE/COMB/DONE SHALL be 00.
REQ-018 An operand equal to 0x8000 (most negative) SHALL be replaced by 0x7FFF before ABS, so abs saturates and never wraps.
REQ-019 COMB SHALL compute t in WIDTH+1 bits with an unsigned local comparison t versus x, and SHALL NOT use the shared unit.
REQ-020 mag SHALL be registered on entry to DONE; maximum result 0xAFFF fits WIDTH unsigned, so there is no overflow.
REQ-021 Back-to-back: start in DONE SHALL be accepted, with done low on the following cycle and the next done 6 cycles after that edge.

Reset
REQ-022 On rst_n=0 (asynchronous, any state, mid-operation included): state=IDLE, ready=1, busy=0, done=0, mag=0, operand/intermediate registers=0.
REQ-023 After rst_n rises, the first start SHALL be accepted on the first clock edge.
REQ-024 An in-flight computation aborted by reset SHALL produce no done pulse.

Structure
REQ-025 The FSM state encoding (3-bit) and the Op codes (ABS=01, MIN=10, MAX=11) SHALL live in the shared package/include, alongside the datapath definitions.
REQ-026 One sub-module SHALL be instantiated: AbsMinMax_16bit, as the shared operator; the controller owns its A, B and Op inputs.
REQ-027 Intermediate registers: a_l, b_l, abs_a, abs_b, x, y (WIDTH each), t (WIDTH+1).

Verification
REQ-028 a=3, b=4, start 1 cycle -> done exactly 6 cycles later, mag=5, busy high for 5 cycles.
REQ-029 a=-100, b=0 -> mag=100 (t=88 < x, so max selects x).
REQ-030 a=0x8000, b=0x8000 -> mag=0xAFFF (x=y=0x7FFF, saturation path).
REQ-031 Back-to-back: (3,4) then start held in DONE with (0,0) -> done pulses 6 cycles apart, mag 5 then 0; a start issued during busy with (7,7) -> ignored.
REQ-032 rst_n low during MAX state of (3,4) -> immediate IDLE, mag=0, no done; a new (6,8) request -> mag=10 (8-1+3).
REQ-033 Op monitor: Op sequence 01,01,11,10,00 across ABS_A..COMB for every request.
